id_exe_stage_reg: RTL and testbench
===================================

Name: id_exe_stage_reg

Overview:
- Pipeline register between the instruction-decode stage and the execute stage of the 5-stage ARM core.
- Captures decoded operands and control bits, and presents them to the execute stage: val2 generator, ALU and branch adder.
- Supports hazard freeze (hold contents) and branch flush (insert bubble).
- Tracks a per-slot valid bit and a saturating bubble counter for debug.

Parameters:
- ADDR_W, 32, width of PC and operand values
- REG_IDX_W, 4, register-index width (R0..R15)
- BUBBLE_CNT_W, 16, width of debug bubble counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- freeze  in  1  hazard-unit stall; hold all contents
- flush  in  1  branch-taken flush; load bubble
- pc_in  in  ADDR_W  PC+4 of decoded instruction
- val_rn_in  in  ADDR_W  Rn read value
- val_rm_in  in  ADDR_W  Rm read value
- imm_in  in  1  I bit
- shift_operand_in  in  12  {rotate_imm[3:0], imm_8} or shift field
- signed_imm_24_in  in  24  branch offset
- dest_in  in  REG_IDX_W  Rd
- src1_in, src2_in  in  REG_IDX_W  Rn/Rm indices, for forwarding
- exe_cmd_in  in  4  ALU command
- mem_r_en_in, mem_w_en_in, wb_en_in, b_in, s_in  in  1 each  control bits
- carry_in  in  1  status-register C flag at decode
- pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2, exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, carry  out  (widths as inputs)  registered copies
- valid  out  1  slot holds a real instruction
- bubble_cnt  out  BUBBLE_CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (rst). No asynchronous paths.
- Priority at each rising edge: rst > flush > freeze > load.
- rst: every output goes to 0, including valid and bubble_cnt.
- flush=1 (regardless of freeze):
  - Control outputs go to 0: wb_en, mem_r_en, mem_w_en, b, s, exe_cmd, valid.
  - Data outputs (pc, val_rn, val_rm, shift_operand, signed_imm_24, dest, src1, src2, imm, carry) also go to 0, so the bubble is deterministic.
  - bubble_cnt increments.
- freeze=1, flush=0: all outputs hold their previous value; bubble_cnt holds.
- Load case (freeze=0, flush=0): every output takes its *_in value; valid=1.
- Latency: exactly 1 cycle from input to output. No combinational path from any input to any output.
- bubble_cnt saturates at all-ones. Once saturated, further flushes leave it unchanged; it does not wrap.
- No width conversion: fields are copied bit-exact. shift_operand stays 12 bits, and the downstream val2 generator decodes it.
- Back-to-back flushes: each cycle inserts a bubble; bubble_cnt increments every cycle.
- Freeze held N cycles: output is stable and equal to the last loaded instruction for all N cycles.
- rst asserted mid-freeze or mid-flush: reset wins; the next cycle after rst deasserts performs a normal load if freeze=0.

Decomposition:
- Shared package core_pkg holds:
  - exe_cmd constants: MOV=4'b0001, MVN=4'b1001, ADD=4'b0010, ADC=4'b0011, SUB=4'b0100, SBC=4'b0101, AND=4'b0110, ORR=4'b0111, EOR=4'b1000, CMP=4'b0100, TST=4'b0110, LDR/STR=4'b0010.
  - Widths: SHIFT_OP_W=12, IMM24_W=24.
- Natural sub-module: pipe_field_reg.
  - Parameterised width.
  - Inputs: d, en, clr; synchronous rst.
  - Behaviour: clr→0, else en→d.
  - Instantiated per field group (data group, control group).
- The bubble counter lives in the top module.

Test Plan:
- Reset, then load: assert rst 2 cycles, check all outputs 0. Release; drive pc_in=0x10, val_rn_in=0x5, exe_cmd_in=ADD, wb_en_in=1. Next edge: pc=0x10, val_rn=0x5, exe_cmd=0010, wb_en=1, valid=1.
- Freeze: load pc_in=0x20, then freeze=1 for 3 cycles while pc_in=0x24. pc stays 0x20 and valid=1 for 3 cycles. After freeze drops, pc=0x24 one cycle later.
- Flush overrides freeze: freeze=1, flush=1 with wb_en_in=1, mem_w_en_in=1. Next edge: wb_en=0, mem_w_en=0, valid=0, all data 0, bubble_cnt=1.
- Back-to-back flushes: 5 consecutive flush cycles. Result: bubble_cnt=5, valid=0 throughout.
- Saturation: with BUBBLE_CNT_W=2, apply 6 flushes. bubble_cnt reaches 3 and stays 3.
- Reset mid-operation: rst=1 together with a normal load of shift_operand_in=12'h3FF. Next edge: all outputs 0, shift_operand=0, bubble_cnt=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the core pipeline: ALU command codes and field widths.
package core_pkg;

  // Fixed instruction-field widths carried through the pipeline.
  localparam int SHIFT_OP_W = 12;
  localparam int IMM24_W    = 24;
  localparam int EXE_CMD_W  = 4;

  // ALU command encodings. Several opcodes share an encoding because the ALU
  // performs the same operation and only the write-back/flag control differs.
  localparam logic [EXE_CMD_W-1:0] EXE_MOV     = 4'b0001;
  localparam logic [EXE_CMD_W-1:0] EXE_MVN     = 4'b1001;
  localparam logic [EXE_CMD_W-1:0] EXE_ADD     = 4'b0010;
  localparam logic [EXE_CMD_W-1:0] EXE_ADC     = 4'b0011;
  localparam logic [EXE_CMD_W-1:0] EXE_SUB     = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_SBC     = 4'b0101;
  localparam logic [EXE_CMD_W-1:0] EXE_AND     = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_ORR     = 4'b0111;
  localparam logic [EXE_CMD_W-1:0] EXE_EOR     = 4'b1000;
  localparam logic [EXE_CMD_W-1:0] EXE_CMP     = 4'b0100;
  localparam logic [EXE_CMD_W-1:0] EXE_TST     = 4'b0110;
  localparam logic [EXE_CMD_W-1:0] EXE_LDR_STR = 4'b0010;

endpackage

// File: rtl/id_exe_stage_reg_if.sv
// Decode-to-execute bus: decoded fields in (from ID) and registered copies out (to EXE).
interface id_exe_stage_reg_if #(
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 4
);
  import core_pkg::*;

  // Decoded instruction from the ID stage.
  logic [ADDR_W-1:0]     pc_in;
  logic [ADDR_W-1:0]     val_rn_in;
  logic [ADDR_W-1:0]     val_rm_in;
  logic                  imm_in;
  logic [SHIFT_OP_W-1:0] shift_operand_in;
  logic [IMM24_W-1:0]    signed_imm_24_in;
  logic [REG_IDX_W-1:0]  dest_in;
  logic [REG_IDX_W-1:0]  src1_in;
  logic [REG_IDX_W-1:0]  src2_in;
  logic [EXE_CMD_W-1:0]  exe_cmd_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic                  wb_en_in;
  logic                  b_in;
  logic                  s_in;
  logic                  carry_in;

  // Registered slot presented to the EXE stage.
  logic [ADDR_W-1:0]     pc;
  logic [ADDR_W-1:0]     val_rn;
  logic [ADDR_W-1:0]     val_rm;
  logic                  imm;
  logic [SHIFT_OP_W-1:0] shift_operand;
  logic [IMM24_W-1:0]    signed_imm_24;
  logic [REG_IDX_W-1:0]  dest;
  logic [REG_IDX_W-1:0]  src1;
  logic [REG_IDX_W-1:0]  src2;
  logic [EXE_CMD_W-1:0]  exe_cmd;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  wb_en;
  logic                  b;
  logic                  s;
  logic                  carry;
  logic                  valid;

  // Decode side: drives the decoded fields, observes the registered slot.
  modport master (
    output pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
           dest_in, src1_in, src2_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
           wb_en_in, b_in, s_in, carry_in,
    input  pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2,
           exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, carry, valid
  );

  // Pipeline register side.
  modport slave (
    input  pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in, signed_imm_24_in,
           dest_in, src1_in, src2_in, exe_cmd_in, mem_r_en_in, mem_w_en_in,
           wb_en_in, b_in, s_in, carry_in,
    output pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, src1, src2,
           exe_cmd, mem_r_en, mem_w_en, wb_en, b, s, carry, valid
  );

endinterface

// File: rtl/pipe_field_reg.sv
// Generic pipeline field register: synchronous clear has priority over load enable.
module pipe_field_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // Capture d when enabled; reset and clear both force a zero bubble.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every pipeline register samples pre-edge values,
    // independent of the order in which always blocks are evaluated.
    if (rst || clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with hazard freeze, branch flush and a debug bubble counter.
module id_exe_stage_reg
  import core_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int REG_IDX_W    = 4,
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    freeze,
  input  logic                    flush,
  id_exe_stage_reg_if.slave       bus,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  // Operand/data group and control group are registered separately so each
  // group maps onto one field register.
  localparam int DATA_W = 3 * ADDR_W + 1 + SHIFT_OP_W + IMM24_W + 3 * REG_IDX_W + 1;
  localparam int CTRL_W = EXE_CMD_W + 6;

  logic [DATA_W-1:0]       w_data_d;
  logic [DATA_W-1:0]       w_data_q;
  logic [CTRL_W-1:0]       w_ctrl_d;
  logic [CTRL_W-1:0]       w_ctrl_q;
  logic                    w_load_en;
  logic [BUBBLE_CNT_W-1:0] r_bubble_cnt;

  // Flush beats freeze inside pipe_field_reg (clr over en).
  assign w_load_en = ~freeze;

  assign w_data_d = {bus.pc_in, bus.val_rn_in, bus.val_rm_in, bus.imm_in,
                     bus.shift_operand_in, bus.signed_imm_24_in, bus.dest_in,
                     bus.src1_in, bus.src2_in, bus.carry_in};

  // A loaded slot is always a real instruction, hence the constant valid bit.
  assign w_ctrl_d = {bus.exe_cmd_in, bus.mem_r_en_in, bus.mem_w_en_in,
                     bus.wb_en_in, bus.b_in, bus.s_in, 1'b1};

  pipe_field_reg #(.W(DATA_W)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_load_en),
    .clr (flush),
    .d   (w_data_d),
    .q   (w_data_q)
  );

  pipe_field_reg #(.W(CTRL_W)) u_ctrl_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_load_en),
    .clr (flush),
    .d   (w_ctrl_d),
    .q   (w_ctrl_q)
  );

  assign {bus.pc, bus.val_rn, bus.val_rm, bus.imm, bus.shift_operand,
          bus.signed_imm_24, bus.dest, bus.src1, bus.src2, bus.carry} = w_data_q;

  assign {bus.exe_cmd, bus.mem_r_en, bus.mem_w_en, bus.wb_en, bus.b, bus.s,
          bus.valid} = w_ctrl_q;

  // Count inserted bubbles; stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (flush && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + BUBBLE_CNT_W'(1);
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg against a slot-level reference model.
module tb_id_exe_stage_reg;
  import core_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;
    logic [3:0]  dest;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  exe_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        b;
    logic        s;
    logic        carry;
    logic        valid;
  } slot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] bubble_cnt;
  logic [1:0]  bubble_cnt_sat;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction expected in the slot plus bubble tallies.
  slot_t cur_in;
  slot_t m_slot;
  int    m_cnt;
  int    m_cnt_sat;

  always #5 clk = ~clk;

  id_exe_stage_reg_if #(.ADDR_W(32), .REG_IDX_W(4)) u_bus ();
  id_exe_stage_reg_if #(.ADDR_W(32), .REG_IDX_W(4)) u_bus_sat ();

  id_exe_stage_reg #(.ADDR_W(32), .REG_IDX_W(4), .BUBBLE_CNT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .bus        (u_bus.slave),
    .bubble_cnt (bubble_cnt)
  );

  // Narrow-counter instance shares control inputs; only its counter is observed.
  id_exe_stage_reg #(.ADDR_W(32), .REG_IDX_W(4), .BUBBLE_CNT_W(2)) u_dut_sat (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .flush      (flush),
    .bus        (u_bus_sat.slave),
    .bubble_cnt (bubble_cnt_sat)
  );

  function automatic slot_t rand_slot();
    slot_t x;
    x.pc            = $urandom;
    x.val_rn        = $urandom;
    x.val_rm        = $urandom;
    x.imm           = 1'($urandom);
    x.shift_operand = 12'($urandom);
    x.signed_imm_24 = 24'($urandom);
    x.dest          = 4'($urandom);
    x.src1          = 4'($urandom);
    x.src2          = 4'($urandom);
    x.exe_cmd       = 4'($urandom);
    x.mem_r_en      = 1'($urandom);
    x.mem_w_en      = 1'($urandom);
    x.wb_en         = 1'($urandom);
    x.b             = 1'($urandom);
    x.s             = 1'($urandom);
    x.carry         = 1'($urandom);
    x.valid         = 1'b0;
    return x;
  endfunction

  function automatic slot_t sample();
    slot_t o;
    o.pc            = u_bus.pc;
    o.val_rn        = u_bus.val_rn;
    o.val_rm        = u_bus.val_rm;
    o.imm           = u_bus.imm;
    o.shift_operand = u_bus.shift_operand;
    o.signed_imm_24 = u_bus.signed_imm_24;
    o.dest          = u_bus.dest;
    o.src1          = u_bus.src1;
    o.src2          = u_bus.src2;
    o.exe_cmd       = u_bus.exe_cmd;
    o.mem_r_en      = u_bus.mem_r_en;
    o.mem_w_en      = u_bus.mem_w_en;
    o.wb_en         = u_bus.wb_en;
    o.b             = u_bus.b;
    o.s             = u_bus.s;
    o.carry         = u_bus.carry;
    o.valid         = u_bus.valid;
    return o;
  endfunction

  task automatic drive(input slot_t x);
    cur_in                 = x;
    u_bus.pc_in            = x.pc;
    u_bus.val_rn_in        = x.val_rn;
    u_bus.val_rm_in        = x.val_rm;
    u_bus.imm_in           = x.imm;
    u_bus.shift_operand_in = x.shift_operand;
    u_bus.signed_imm_24_in = x.signed_imm_24;
    u_bus.dest_in          = x.dest;
    u_bus.src1_in          = x.src1;
    u_bus.src2_in          = x.src2;
    u_bus.exe_cmd_in       = x.exe_cmd;
    u_bus.mem_r_en_in      = x.mem_r_en;
    u_bus.mem_w_en_in      = x.mem_w_en;
    u_bus.wb_en_in         = x.wb_en;
    u_bus.b_in             = x.b;
    u_bus.s_in             = x.s;
    u_bus.carry_in         = x.carry;
  endtask

  // One clock with the given controls; the model applies rst > flush > freeze > load.
  task automatic step(input logic r, input logic fz, input logic fl);
    rst    = r;
    freeze = fz;
    flush  = fl;
    @(posedge clk);
    if (r) begin
      m_slot    = '0;
      m_cnt     = 0;
      m_cnt_sat = 0;
    end else if (fl) begin
      m_slot    = '0;
      m_cnt     = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      m_cnt_sat = (m_cnt_sat < 3) ? m_cnt_sat + 1 : m_cnt_sat;
    end else if (!fz) begin
      m_slot       = cur_in;
      m_slot.valid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    slot_t got;
    drive(rand_slot());
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    got = sample();
    n_tests++;
    if (got !== slot_t'(0)) begin
      n_fail++;
      $display("FAIL reset_slot got=%h exp=0", got);
    end
    n_tests++;
    if (bubble_cnt !== 16'd0 || bubble_cnt_sat !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bubble_cnt, bubble_cnt_sat);
    end
  endtask

  task automatic test_load();
    slot_t x;
    slot_t got;
    x         = '0;
    x.pc      = 32'h10;
    x.val_rn  = 32'h5;
    x.exe_cmd = EXE_ADD;
    x.wb_en   = 1'b1;
    drive(x);
    step(1'b0, 1'b0, 1'b0);
    got = sample();
    n_tests++;
    if (got.pc !== 32'h10 || got.val_rn !== 32'h5 || got.exe_cmd !== 4'b0010 ||
        got.wb_en !== 1'b1 || got.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL load_directed got=%h", got);
    end
    n_tests++;
    if (got !== m_slot) begin
      n_fail++;
      $display("FAIL load_slot got=%h exp=%h", got, m_slot);
    end
  endtask

  task automatic test_freeze();
    slot_t x;
    slot_t got;
    x    = rand_slot();
    x.pc = 32'h20;
    drive(x);
    step(1'b0, 1'b0, 1'b0);
    x    = rand_slot();
    x.pc = 32'h24;
    drive(x);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      got = sample();
      n_tests++;
      if (got.pc !== 32'h20 || got.valid !== 1'b1 || got !== m_slot) begin
        n_fail++;
        $display("FAIL freeze_hold[%0d] got=%h exp=%h", i, got, m_slot);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    got = sample();
    n_tests++;
    if (got.pc !== 32'h24 || got !== m_slot) begin
      n_fail++;
      $display("FAIL freeze_release got=%h exp=%h", got, m_slot);
    end
  endtask

  task automatic test_flush_over_freeze();
    slot_t x;
    slot_t got;
    x          = rand_slot();
    x.wb_en    = 1'b1;
    x.mem_w_en = 1'b1;
    drive(x);
    step(1'b0, 1'b1, 1'b1);
    got = sample();
    n_tests++;
    if (got !== slot_t'(0)) begin
      n_fail++;
      $display("FAIL flush_slot got=%h exp=0", got);
    end
    n_tests++;
    if (bubble_cnt !== 16'd1 || bubble_cnt_sat !== 2'd1) begin
      n_fail++;
      $display("FAIL flush_cnt got=%0d/%0d exp=1/1", bubble_cnt, bubble_cnt_sat);
    end
  endtask

  task automatic test_back_to_back();
    slot_t got;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(rand_slot());
      step(1'b0, 1'($urandom), 1'b1);
      got = sample();
      n_tests++;
      if (got.valid !== 1'b0 || 32'(bubble_cnt) !== i + 1) begin
        n_fail++;
        $display("FAIL b2b_flush[%0d] valid=%b cnt=%0d exp_cnt=%0d", i, got.valid,
                 bubble_cnt, i + 1);
      end
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(rand_slot());
      step(1'b0, 1'b0, 1'b1);
      n_tests++;
      if (32'(bubble_cnt_sat) !== ((i < 3) ? i + 1 : 3) || 32'(bubble_cnt) !== i + 1) begin
        n_fail++;
        $display("FAIL saturate[%0d] got=%0d/%0d", i, bubble_cnt_sat, bubble_cnt);
      end
    end
    // A load after saturation must not disturb the counter.
    step(1'b0, 1'b0, 1'b0);
    n_tests++;
    if (bubble_cnt_sat !== 2'd3) begin
      n_fail++;
      $display("FAIL saturate_hold got=%0d exp=3", bubble_cnt_sat);
    end
  endtask

  task automatic test_reset_mid();
    slot_t x;
    slot_t got;
    drive(rand_slot());
    step(1'b0, 1'b0, 1'b1);
    x               = rand_slot();
    x.shift_operand = 12'h3FF;
    drive(x);
    step(1'b1, 1'b0, 1'b0);
    got = sample();
    n_tests++;
    if (got !== slot_t'(0) || got.shift_operand !== 12'h000 || bubble_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_load got=%h cnt=%0d", got, bubble_cnt);
    end
    step(1'b1, 1'b1, 1'b1);
    got = sample();
    n_tests++;
    if (got !== slot_t'(0) || bubble_cnt !== 16'd0 || bubble_cnt_sat !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_over_flush got=%h cnt=%0d/%0d", got, bubble_cnt, bubble_cnt_sat);
    end
    drive(rand_slot());
    step(1'b0, 1'b0, 1'b0);
    got = sample();
    n_tests++;
    if (got !== m_slot || got.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release got=%h exp=%h", got, m_slot);
    end
  endtask

  task automatic test_random();
    slot_t got;
    logic  r;
    logic  fz;
    logic  fl;
    for (int i = 0; i < 300; i++) begin
      drive(rand_slot());
      r  = ($urandom_range(0, 31) == 0);
      fz = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 3) == 0);
      step(r, fz, fl);
      got = sample();
      n_tests++;
      if (got !== m_slot || 32'(bubble_cnt) !== m_cnt ||
          32'(bubble_cnt_sat) !== m_cnt_sat) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h cnt=%0d/%0d exp=%h cnt=%0d/%0d", i, got,
                 bubble_cnt, bubble_cnt_sat, m_slot, m_cnt, m_cnt_sat);
      end
    end
  endtask

  initial begin
    m_slot    = '0;
    m_cnt     = 0;
    m_cnt_sat = 0;
    u_bus_sat.pc_in            = '0;
    u_bus_sat.val_rn_in        = '0;
    u_bus_sat.val_rm_in        = '0;
    u_bus_sat.imm_in           = 1'b0;
    u_bus_sat.shift_operand_in = '0;
    u_bus_sat.signed_imm_24_in = '0;
    u_bus_sat.dest_in          = '0;
    u_bus_sat.src1_in          = '0;
    u_bus_sat.src2_in          = '0;
    u_bus_sat.exe_cmd_in       = '0;
    u_bus_sat.mem_r_en_in      = 1'b0;
    u_bus_sat.mem_w_en_in      = 1'b0;
    u_bus_sat.wb_en_in         = 1'b0;
    u_bus_sat.b_in             = 1'b0;
    u_bus_sat.s_in             = 1'b0;
    u_bus_sat.carry_in         = 1'b0;

    test_reset();
    test_load();
    test_freeze();
    test_flush_over_freeze();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
